// File: rtl/fifo_burst_reader.sv
`default_nettype none
// ============================================================================
// Module      : fifo_burst_reader
// Description : Pulls bursts from a synchronous FIFO and streams them out on a
//               valid/ready port, flushing partial bursts after an idle timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_burst_reader #(
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = 4,
    parameter int TIMEOUT   = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        existed_entries,
    input  logic              empty,
    output logic              rd_en,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic [7:0]        burst_count
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_BURST  = 2'd1;
    localparam logic [1:0] c_ST_DRAIN  = 2'd2;
    localparam logic [3:0] c_BURST_LEN = 4'(BURST_LEN);
    localparam logic [7:0] c_TIMEOUT   = 8'(TIMEOUT);

    logic [1:0]        r_state;
    logic [3:0]        r_len;
    logic [3:0]        r_issued;
    logic [7:0]        r_timer;
    logic              r_rd_pend;
    logic              r_rd_last;
    logic [DATA_W-1:0] r_buf_data [2];
    logic [1:0]        r_buf_last;
    logic [1:0]        r_buf_cnt;
    logic [7:0]        r_burst_count;

    logic              w_pop;
    logic [2:0]        w_occ;
    logic              w_room;
    logic              w_rd_en;
    logic              w_last_issue;
    logic              w_wr_hi;

    assign w_pop        = out_valid & out_ready;
    assign w_occ        = {1'b0, r_buf_cnt} + {2'b00, r_rd_pend};
    // A beat leaving this cycle frees a slot for the read issued now.
    assign w_room       = w_occ < (3'd2 + {2'b00, w_pop});
    assign w_rd_en      = !rst && (r_state == c_ST_BURST) && (r_issued < r_len)
                          && !empty && w_room;
    assign w_last_issue = w_rd_en && (r_issued == (r_len - 4'd1));
    assign w_wr_hi      = (r_buf_cnt == 2'd2) || ((r_buf_cnt == 2'd1) && !w_pop);

    assign rd_en       = w_rd_en;
    assign out_valid   = (r_buf_cnt != 2'd0);
    assign out_data    = r_buf_data[0];
    assign out_last    = r_buf_last[0];
    assign busy        = (r_state != c_ST_IDLE);
    assign burst_count = r_burst_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_ST_IDLE;
            r_len         <= 4'd0;
            r_issued      <= 4'd0;
            r_timer       <= 8'd0;
            r_rd_pend     <= 1'b0;
            r_rd_last     <= 1'b0;
            r_buf_data[0] <= '0;
            r_buf_data[1] <= '0;
            r_buf_last    <= 2'b00;
            r_buf_cnt     <= 2'd0;
            r_burst_count <= 8'd0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (existed_entries >= c_BURST_LEN) begin
                        r_len    <= c_BURST_LEN;
                        r_issued <= 4'd0;
                        r_timer  <= 8'd0;
                        r_state  <= c_ST_BURST;
                    end else if ((r_timer == c_TIMEOUT) && !empty
                                 && (existed_entries != 4'd0)) begin
                        // Zero-length flush would never complete, so it is skipped.
                        r_len    <= existed_entries;
                        r_issued <= 4'd0;
                        r_timer  <= 8'd0;
                        r_state  <= c_ST_BURST;
                    end else if (empty) begin
                        r_timer <= 8'd0;
                    end else if (r_timer != c_TIMEOUT) begin
                        r_timer <= r_timer + 8'd1;
                    end
                end
                c_ST_BURST: begin
                    if (w_rd_en) begin
                        r_issued <= r_issued + 4'd1;
                    end
                    if (w_last_issue) begin
                        r_state <= c_ST_DRAIN;
                    end
                end
                c_ST_DRAIN: begin
                    if (w_pop && r_buf_last[0]) begin
                        r_burst_count <= r_burst_count + 8'd1;
                        r_state       <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase

            r_rd_pend <= w_rd_en;
            r_rd_last <= w_last_issue;

            if (w_pop) begin
                r_buf_data[0] <= r_buf_data[1];
                r_buf_last[0] <= r_buf_last[1];
            end
            if (r_rd_pend) begin
                if (w_wr_hi) begin
                    r_buf_data[1] <= rd_data;
                    r_buf_last[1] <= r_rd_last;
                end else begin
                    r_buf_data[0] <= rd_data;
                    r_buf_last[0] <= r_rd_last;
                end
            end
            r_buf_cnt <= r_buf_cnt + {1'b0, r_rd_pend} - {1'b0, w_pop};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_burst_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_burst_reader
// Description : Directed bench for fifo_burst_reader with a FIFO model and an
//               in-order beat scoreboard checked every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_burst_reader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] existed_entries = 4'd0;
    logic       empty = 1'b1;
    logic       rd_en;
    logic [7:0] rd_data = 8'd0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic       out_last;
    logic       busy;
    logic [7:0] burst_count;

    fifo_burst_reader #(.DATA_W(8), .BURST_LEN(4), .TIMEOUT(15)) dut (
        .clk             (clk),
        .rst             (rst),
        .existed_entries (existed_entries),
        .empty           (empty),
        .rd_en           (rd_en),
        .rd_data         (rd_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .out_last        (out_last),
        .busy            (busy),
        .burst_count     (burst_count)
    );

    always #5 clk = ~clk;

    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] fq[$];
    logic [7:0] exp_data[$];
    int         exp_len[$];
    int         m_beat = 0;
    int         m_out = 0;
    logic [7:0] m_bursts = 8'd0;
    logic       rd_en_prev = 1'b0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'd0;
    logic       prev_last = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic push_data(input logic [7:0] d);
        fq.push_back(d);
        exp_data.push_back(d);
    endtask

    task automatic score();
        logic el;
        chk("burst_count", 32'(burst_count), 32'(m_bursts));
        chk("rd_en_outside_burst", 32'(rd_en & ~busy), 0);
        if (prev_stall) begin
            chk("hold_valid", 32'(out_valid), 1);
            chk("hold_data", 32'(out_data), 32'(prev_data));
            chk("hold_last", 32'(out_last), 32'(prev_last));
        end
        if (rd_en) m_out++;
        if (out_valid && out_ready) begin
            if (exp_data.size() == 0 || exp_len.size() == 0) begin
                chk("unexpected_beat", 1, 0);
            end else begin
                chk("beat_data", 32'(out_data), 32'(exp_data.pop_front()));
                el = (m_beat + 1 == exp_len[0]);
                chk("beat_last", 32'(out_last), 32'(el));
                if (el) begin
                    void'(exp_len.pop_front());
                    m_beat = 0;
                    m_bursts++;
                end else begin
                    m_beat++;
                end
            end
            m_out--;
        end
        chk("in_flight_le_2", 32'(m_out <= 2), 1);
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_last  = out_last;
    endtask

    // One cycle: FIFO model reacts at the falling edge, outputs checked just after.
    task automatic tick(input logic rdy);
        @(negedge clk);
        if (rd_en_prev) begin
            if (fq.size() == 0) chk("read_when_empty", 1, 0);
            else rd_data = fq.pop_front();
        end
        out_ready       = rdy;
        existed_entries = 4'(fq.size());
        empty           = (fq.size() == 0);
        #1;
        if (!rst) score();
        rd_en_prev = rd_en;
    endtask

    task automatic reset_dut(input string tag);
        rst = 1'b1;
        fq.delete();
        exp_data.delete();
        exp_len.delete();
        m_beat = 0;
        m_out = 0;
        m_bursts = 8'd0;
        rd_en_prev = 1'b0;
        prev_stall = 1'b0;
        tick(1'b1);
        chk({tag, "_rd_en"}, 32'(rd_en), 0);
        chk({tag, "_out_valid"}, 32'(out_valid), 0);
        chk({tag, "_out_last"}, 32'(out_last), 0);
        chk({tag, "_out_data"}, 32'(out_data), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_burst_count"}, 32'(burst_count), 0);
        rst = 1'b0;
    endtask

    task automatic run_until_idle(input int mode, input int maxc);
        int n = 0;
        do begin
            tick((mode == 0) ? 1'b1 : ((n % 3) == 0));
            n++;
        end while ((exp_len.size() != 0 || busy) && n < maxc);
        chk("run_complete", 32'(exp_len.size() == 0 && !busy), 1);
        chk("data_consumed", 32'(exp_data.size()), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic e_rd   [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic e_vld  [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic e_last [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic e_busy [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        reset_dut("reset");

        // Full burst: threshold at cycle N, reads N+1..N+4, beats N+3..N+6.
        for (int i = 0; i < 4; i++) push_data(8'hA1 + 8'(i));
        exp_len.push_back(4);
        tick(1'b1);
        chk("t1_n_busy", 32'(busy), 0);
        chk("t1_n_rd_en", 32'(rd_en), 0);
        for (int k = 0; k < 7; k++) begin
            tick(1'b1);
            chk("t1_rd_en", 32'(rd_en), 32'(e_rd[k]));
            chk("t1_out_valid", 32'(out_valid), 32'(e_vld[k]));
            chk("t1_out_last", 32'(out_last), 32'(e_last[k]));
            chk("t1_busy", 32'(busy), 32'(e_busy[k]));
            if (k == 2) chk("t1_first_data", 32'(out_data), 32'h A1);
            if (k == 5) chk("t1_last_data", 32'(out_data), 32'h A4);
        end
        chk("t1_bursts", 32'(burst_count), 1);

        // Partial burst of 2 flushed after 15 sub-threshold cycles.
        push_data(8'h11);
        push_data(8'h22);
        exp_len.push_back(2);
        tick(1'b1);
        for (int k = 1; k <= 15; k++) begin
            tick(1'b1);
            chk("t2_wait_busy", 32'(busy), 0);
        end
        tick(1'b1);
        chk("t2_flush_busy", 32'(busy), 1);
        chk("t2_flush_rd_en", 32'(rd_en), 1);
        run_until_idle(0, 40);
        chk("t2_bursts", 32'(burst_count), 2);

        // Eight entries under 1,0,0 backpressure: two bursts of four.
        for (int i = 0; i < 8; i++) push_data(8'h30 + 8'(i));
        exp_len.push_back(4);
        exp_len.push_back(4);
        run_until_idle(1, 200);
        chk("t3_bursts", 32'(burst_count), 4);

        // Threshold and timeout coincide: length must be BURST_LEN, not 6.
        push_data(8'h51);
        push_data(8'h52);
        tick(1'b1);
        for (int k = 1; k <= 14; k++) tick(1'b1);
        for (int i = 0; i < 4; i++) push_data(8'h53 + 8'(i));
        exp_len.push_back(4);
        exp_len.push_back(2);
        tick(1'b1);
        chk("t4_decide_busy", 32'(busy), 0);
        tick(1'b1);
        chk("t4_burst_busy", 32'(busy), 1);
        run_until_idle(0, 80);
        chk("t4_bursts", 32'(burst_count), 6);

        // Reset after two reads with one pending, then a clean burst.
        for (int i = 0; i < 4; i++) push_data(8'hC1 + 8'(i));
        exp_len.push_back(4);
        tick(1'b1);
        tick(1'b1);
        tick(1'b1);
        chk("t5_pre_rd_en", 32'(rd_en), 1);
        reset_dut("t5_reset");
        for (int i = 0; i < 4; i++) push_data(8'hD1 + 8'(i));
        exp_len.push_back(4);
        run_until_idle(0, 40);
        chk("t5_bursts", 32'(burst_count), 1);

        // 255 more bursts wrap the counter to zero.
        for (int b = 0; b < 255; b++) begin
            for (int j = 0; j < 4; j++) push_data(8'(b * 4 + j));
            exp_len.push_back(4);
            run_until_idle(0, 40);
        end
        chk("t6_wrap", 32'(burst_count), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
- Downstream consumer of the synchronous FIFO pointer/status controller.
- Watches the controller's `existed_entries` and `empty`, and issues `rd_en` in bursts.
- Captures the FIFO storage read data, which arrives one cycle after `rd_en`.
- Presents beats on a valid/ready stream with a burst-final flag.
- A timeout flushes a partial burst when the FIFO holds data below the burst threshold.

Parameters:
- DATA_W, 8, width of FIFO data and output stream.
- BURST_LEN, 4, beats per full burst; legal range 1..15, because `existed_entries` is 4 bits.
- TIMEOUT, 15, cycles of sub-threshold non-empty occupancy before a partial-burst flush; range 1..255.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- existed_entries  in  4  occupancy from FIFO controller.
- empty  in  1  FIFO empty flag from controller.
- rd_en  out  1  read request to FIFO controller and storage.
- rd_data  in  DATA_W  storage read data; valid in the cycle after `rd_en`.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accept.
- out_data  out  DATA_W  output beat payload.
- out_last  out  1  marks the final beat of a burst.
- busy  out  1  high when state is not IDLE.
- burst_count  out  8  number of completed bursts; wraps 255->0.

Behaviour:
- Reset (sampled on `clk` when `rst`=1):
  - State goes to IDLE.
  - `rd_en`=0, `out_valid`=0, `out_last`=0, `out_data`=0, `busy`=0, `burst_count`=0.
  - Output buffer is emptied, the pending-read flag is cleared, and the idle timer is cleared.
  - A read in flight during reset is discarded. The FIFO controller is reset alongside this block.
- State machine: IDLE, BURST, DRAIN.
- IDLE:
  - The idle timer increments while `empty`=0 and `existed_entries` < BURST_LEN.
  - The idle timer clears when `empty`=1, or on leaving IDLE.
  - If `existed_entries` >= BURST_LEN: capture `len_q`=BURST_LEN and go to BURST.
  - Otherwise, if the timer equals TIMEOUT and `empty`=0: capture `len_q`=`existed_entries` and go to BURST.
  - Threshold takes priority over timeout.
- BURST:
  - `rd_en`=1 when all of the following hold:
    - issued < `len_q`
    - `empty`=0
    - (buf_cnt + rd_pend − pop) < 2, where pop = `out_valid` & `out_ready`.
  - When the last read is issued (issued+1 == `len_q` with `rd_en`=1), go to DRAIN next cycle.
  - `rd_en` is never asserted outside BURST. Because `len_q` <= captured occupancy, `rd_en` never hits an empty FIFO.
- DRAIN:
  - No reads.
  - On the accept of the beat with `out_last`=1: increment `burst_count` and go to IDLE.
- Read pipeline:
  - `rd_pend` is a register: 1 in the cycle after `rd_en`.
  - In that cycle `rd_data` is written into a 2-entry output FIFO buffer.
  - Each entry carries {data, last}; last=1 for beat index `len_q`−1.
- Output:
  - `out_valid` = buf_cnt != 0; `out_data` and `out_last` come from the buffer head.
  - Push and pop in the same cycle are allowed and leave buf_cnt unchanged.
  - `out_data` and `out_last` hold stable while `out_valid`=1 and `out_ready`=0.
- Latency: threshold seen in IDLE at cycle N:
  - BURST at N+1 with first `rd_en` at N+1.
  - `rd_pend` at N+2.
  - `out_valid` at N+3.
- Throughput: 1 beat/cycle sustained while `out_ready`=1.
- Backpressure: `out_ready`=0 throttles `rd_en` to at most 2 beats buffered/in flight; no data is ever dropped or duplicated.
- `busy` = (state != IDLE).
- A burst of `len_q`=1 asserts `out_last` on its only beat.

Test Plan:
- Reset, then write 4 entries (`existed_entries` rises to 4), `out_ready`=1 -> 4 consecutive `rd_en` cycles; `out_valid` for 4 consecutive cycles starting 3 cycles after threshold; `out_last` on beat 4; `burst_count`=1; back to IDLE.
- 2 entries held, no further writes -> after 15 idle cycles a burst of `len_q`=2; `out_last` on beat 2; `burst_count` increments.
- 8 entries, `out_ready` toggling 1,0,0,1... -> data order preserved; buffer never exceeds 2; two bursts of 4, each with `out_last` on beat 4; `rd_en` deasserts during stalls.
- Threshold and timeout both true in the same IDLE cycle (4 entries) -> `len_q`=BURST_LEN (4), not the partial count.
- `rst`=1 mid-burst (after 2 reads, with 1 pending) -> next cycle: state IDLE, `out_valid`=0, `rd_en`=0, `burst_count`=0; pending data discarded.
- 256 completed bursts -> `burst_count` wraps to 0.
